// File: rtl/vidgen_raster.sv
// Raster timing generator (336x240 in 456x262) with a 2-stage line-buffer -> palette pixel pipeline.
// Optional build macro VIDGEN_TESTPAT_EN adds test_en, which substitutes 8 colour bars for palette data.
module vidgen_raster #(
    parameter int PIXDIV   = 1,
    parameter int H_ACTIVE = 336,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 80,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 15
) (
    input  logic        MCKF,
    input  logic        reset,
`ifdef VIDGEN_TESTPAT_EN
    input  logic        test_en,
`endif
    output logic [8:0]  lb_addr,
    input  logic [7:0]  lb_data,
    output logic [7:0]  pal_addr,
    input  logic [15:0] pal_data,
    output logic [15:0] VIDOUT,
    output logic        VIDBLANK_b,
    output logic        HSYNC_b,
    output logic        VSYNC_b,
    output logic [8:0]  hcnt,
    output logic [8:0]  vcnt,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIVW    = (PIXDIV > 1) ? $clog2(PIXDIV) : 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PIXDIV - 1);
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_VIS    = 9'(H_ACTIVE);
    localparam logic [8:0] V_VIS    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_START = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] VS_START = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END   = 9'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIVW-1:0] divCnt_q, divCnt_d;
    logic [8:0]      hCnt_q, hCnt_d;
    logic [8:0]      vCnt_q, vCnt_d;
    logic            pixEn;
    logic            hEnd, vEnd;
    logic            rawActive, rawHs, rawVs;

    logic [7:0]      palAddr_q;
    logic            act1_q, hs1_q, vs1_q;
    logic [15:0]     vidOut_q;
    logic            blankB_q, hsyncB_q, vsyncB_q;
    logic [15:0]     vidSrc;

`ifdef VIDGEN_TESTPAT_EN
    logic [2:0]      bar;
    logic [11:0]     barColour;
    logic            test1_q;
    logic [11:0]     bar1_q;
`endif

    always_comb begin
        pixEn    = (divCnt_q == DIV_LAST);
        divCnt_d = pixEn ? '0 : divCnt_q + 1'b1;
    end

    always_comb begin
        hEnd   = (hCnt_q == H_LAST);
        vEnd   = (vCnt_q == V_LAST);
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (pixEn) begin
            hCnt_d = hEnd ? 9'd0 : hCnt_q + 9'd1;
            if (hEnd) begin
                vCnt_d = vEnd ? 9'd0 : vCnt_q + 9'd1;
            end
        end
    end

    always_comb begin
        rawActive = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
        rawHs     = (hCnt_q >= HS_START) && (hCnt_q < HS_END);
        rawVs     = (vCnt_q >= VS_START) && (vCnt_q < VS_END);
    end

`ifdef VIDGEN_TESTPAT_EN
    // Eight 42-pixel bars; columns past the visible area give don't-care bars that blanking hides.
    always_comb begin
        bar       = 3'(hCnt_q / 9'd42);
        barColour = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        vidSrc    = test1_q ? {4'h0, bar1_q} : pal_data;
    end
`else
    always_comb begin
        vidSrc = pal_data;
    end
`endif

    always_ff @(posedge MCKF or posedge reset) begin
        if (reset) begin
            divCnt_q <= '0;
            hCnt_q   <= 9'd0;
            vCnt_q   <= 9'd0;
        end else begin
            divCnt_q <= divCnt_d;
            hCnt_q   <= hCnt_d;
            vCnt_q   <= vCnt_d;
        end
    end

    // Stage 1 latches the palette address and raw timing; stage 2 resolves colour and aligns syncs with it.
    always_ff @(posedge MCKF or posedge reset) begin
        if (reset) begin
            palAddr_q <= 8'd0;
            act1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            vidOut_q  <= 16'h0000;
            blankB_q  <= 1'b0;
            hsyncB_q  <= 1'b1;
            vsyncB_q  <= 1'b1;
`ifdef VIDGEN_TESTPAT_EN
            test1_q   <= 1'b0;
            bar1_q    <= 12'h000;
`endif
        end else if (pixEn) begin
            palAddr_q <= lb_data;
            act1_q    <= rawActive;
            hs1_q     <= rawHs;
            vs1_q     <= rawVs;
            vidOut_q  <= act1_q ? vidSrc : 16'h0000;
            blankB_q  <= act1_q;
            hsyncB_q  <= ~hs1_q;
            vsyncB_q  <= ~vs1_q;
`ifdef VIDGEN_TESTPAT_EN
            test1_q   <= test_en;
            bar1_q    <= barColour;
`endif
        end
    end

    assign lb_addr     = hCnt_q;
    assign hcnt        = hCnt_q;
    assign vcnt        = vCnt_q;
    assign pal_addr    = palAddr_q;
    assign VIDOUT      = vidOut_q;
    assign VIDBLANK_b  = blankB_q;
    assign HSYNC_b     = hsyncB_q;
    assign VSYNC_b     = vsyncB_q;
    assign frame_start = pixEn && hEnd && vEnd;

endmodule

// File: tb/tb_vidgen_raster.sv
// Bench for vidgen_raster: PIXDIV=1 and PIXDIV=3 instances on a shortened frame, checked every cycle
// against a slot-arithmetic reference model; memories are combinational with randomised contents.
module tb_vidgen_raster;

    localparam int HA = 336, HFP = 8, HSY = 32, HBP = 80;
    localparam int VA = 8,   VFP = 2, VSY = 3,  VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;

    typedef struct {
        int lbAddr;
        int hcnt;
        int vcnt;
        int palAddr;
        int vidOut;
        int blankB;
        int hsB;
        int vsB;
        int fs;
    } expT;

    logic MCKF  = 1'b0;
    logic reset = 1'b0;
    logic testEn = 1'b0;
    logic [7:0] lbKey = 8'h00;
    logic [7:0] palHi = 8'hA5;

    logic [8:0]  lbAddr1, hcnt1, vcnt1, lbAddr3, hcnt3, vcnt3;
    logic [7:0]  lbData1, palAddr1, lbData3, palAddr3;
    logic [15:0] palData1, vidOut1, palData3, vidOut3;
    logic        blankB1, hsB1, vsB1, fs1, blankB3, hsB3, vsB3, fs3;

    int cyc;
    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int lastFs     = -1;

    vidgen_raster #(.PIXDIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut1 (
        .MCKF(MCKF), .reset(reset),
`ifdef VIDGEN_TESTPAT_EN
        .test_en(testEn),
`endif
        .lb_addr(lbAddr1), .lb_data(lbData1), .pal_addr(palAddr1), .pal_data(palData1),
        .VIDOUT(vidOut1), .VIDBLANK_b(blankB1), .HSYNC_b(hsB1), .VSYNC_b(vsB1),
        .hcnt(hcnt1), .vcnt(vcnt1), .frame_start(fs1)
    );

    vidgen_raster #(.PIXDIV(3), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut3 (
        .MCKF(MCKF), .reset(reset),
`ifdef VIDGEN_TESTPAT_EN
        .test_en(testEn),
`endif
        .lb_addr(lbAddr3), .lb_data(lbData3), .pal_addr(palAddr3), .pal_data(palData3),
        .VIDOUT(vidOut3), .VIDBLANK_b(blankB3), .HSYNC_b(hsB3), .VSYNC_b(vsB3),
        .hcnt(hcnt3), .vcnt(vcnt3), .frame_start(fs3)
    );

    assign lbData1  = lbAddr1[7:0] ^ lbKey;
    assign palData1 = {palHi, palAddr1};
    assign lbData3  = lbAddr3[7:0] ^ lbKey;
    assign palData3 = {palHi, palAddr3};

    always #5 MCKF = ~MCKF;

    // Clock edges seen since reset release; the model derives every output from this alone.
    always @(posedge MCKF or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic expT model(input int c, input int pd);
        expT e;
        int s, p, hp, vp, bar;
        bit act;
        s = c / pd;
        e.lbAddr  = s % HT;
        e.hcnt    = s % HT;
        e.vcnt    = (s / HT) % VT;
        e.fs      = ((c % pd) == pd - 1 && (s % FT) == FT - 1) ? 1 : 0;
        e.palAddr = (s >= 1) ? ((((s - 1) % HT) & 255) ^ int'(lbKey)) : 0;
        e.vidOut  = 0;
        e.blankB  = 0;
        e.hsB     = 1;
        e.vsB     = 1;
        if (s >= 2) begin
            p   = s - 2;
            hp  = p % HT;
            vp  = (p / HT) % VT;
            act = (hp < HA) && (vp < VA);
            e.blankB = act ? 1 : 0;
            e.hsB    = (hp >= HA + HFP && hp < HA + HFP + HSY) ? 0 : 1;
            e.vsB    = (vp >= VA + VFP && vp < VA + VFP + VSY) ? 0 : 1;
            if (act) begin
                if (testEn) begin
                    bar = hp / 42;
                    e.vidOut = ((bar & 4) != 0 ? 'hF00 : 0) | ((bar & 2) != 0 ? 'h0F0 : 0)
                             | ((bar & 1) != 0 ? 'h00F : 0);
                end else begin
                    e.vidOut = (int'(palHi) << 8) | ((hp & 255) ^ int'(lbKey));
                end
            end
        end
        return e;
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        expT e1, e3;
        e1 = model(cyc, 1);
        e3 = model(cyc, 3);
        checkOne("lb_addr/d1",     lbAddr1,  e1.lbAddr);
        checkOne("hcnt/d1",        hcnt1,    e1.hcnt);
        checkOne("vcnt/d1",        vcnt1,    e1.vcnt);
        checkOne("pal_addr/d1",    palAddr1, e1.palAddr);
        checkOne("VIDOUT/d1",      vidOut1,  e1.vidOut);
        checkOne("VIDBLANK_b/d1",  blankB1,  e1.blankB);
        checkOne("HSYNC_b/d1",     hsB1,     e1.hsB);
        checkOne("VSYNC_b/d1",     vsB1,     e1.vsB);
        checkOne("frame_start/d1", fs1,      e1.fs);
        checkOne("lb_addr/d3",     lbAddr3,  e3.lbAddr);
        checkOne("hcnt/d3",        hcnt3,    e3.hcnt);
        checkOne("vcnt/d3",        vcnt3,    e3.vcnt);
        checkOne("pal_addr/d3",    palAddr3, e3.palAddr);
        checkOne("VIDOUT/d3",      vidOut3,  e3.vidOut);
        checkOne("VIDBLANK_b/d3",  blankB3,  e3.blankB);
        checkOne("HSYNC_b/d3",     hsB3,     e3.hsB);
        checkOne("VSYNC_b/d3",     vsB3,     e3.vsB);
        checkOne("frame_start/d3", fs3,      e3.fs);
        if (fs1 === 1'b1) begin
            if (lastFs >= 0) checkOne("frame_period/d1", cyc - lastFs, FT);
            lastFs = cyc;
        end
    endtask

    task automatic applyStimulus(input int nCycles);
        repeat (nCycles) begin
            @(negedge MCKF);
            checkOutput();
        end
    endtask

    task automatic pulseReset(input int holdCycles);
        reset  = 1'b1;
        lastFs = -1;
        #1 checkOutput();
        applyStimulus(holdCycles);
        @(negedge MCKF);
        reset = 1'b0;
        checkOutput();
    endtask

    initial begin
        bit found;
        $display("[TB] start: frame %0d pixels, PIXDIV 1 and 3", FT);

        #2;
        pulseReset(2);
        applyStimulus(3 * FT + 600);

        found = 1'b0;
        for (int i = 0; i < FT && !found; i++) begin
            @(negedge MCKF);
            checkOutput();
            if (hcnt1 == 9'd200 && vcnt1 == 9'd5) found = 1'b1;
        end
        if (!found) checkOne("wait_reset_point", 0, 1);

        // Memory contents change only while reset holds the pipeline empty.
        lbKey = 8'($urandom);
        palHi = 8'($urandom);
        pulseReset(5);
        $display("[TB] mid-frame reset done, lbKey=%0h palHi=%0h", lbKey, palHi);
        applyStimulus(3 * FT + 600);

        @(negedge MCKF);
        lbKey = 8'($urandom);
        palHi = 8'($urandom);
`ifdef VIDGEN_TESTPAT_EN
        testEn = 1'b1;
`endif
        pulseReset($urandom_range(1, 4));
        applyStimulus(FT + 600);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
